// File: rtl/uibi_arbiter_pkg.sv
// Shared types and constants for the UIBI two-master arbiter: FSM states,
// owner encoding and the bus access mode codes.
package uibi_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   localparam logic ARB_OWN_I = 1'b0;
   localparam logic ARB_OWN_D = 1'b1;

   localparam logic [2:0] BUS_NULL = 3'd0;
   localparam logic [2:0] BUS_QUAR = 3'd1;
   localparam logic [2:0] BUS_HALF = 3'd2;
   localparam logic [2:0] BUS_FULL = 3'd3;

   // Unknown or NULL modes are treated as misaligned so they never reach the bus.
   function automatic logic is_misaligned(input logic [1:0] addr_lsb,
                                          input logic [2:0] mode);
      logic bad;
      case (mode)
         BUS_QUAR: bad = 1'b0;
         BUS_HALF: bad = addr_lsb[0];
         BUS_FULL: bad = (addr_lsb != 2'b00);
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/uibi_align_check.sv
// Combinational alignment screen for one requester: flags accesses whose
// address low bits do not suit the requested mode.
module uibi_align_check
   import uibi_arbiter_pkg::*;
(
   input  logic [1:0] addr_lsb,
   input  logic [2:0] mode,
   output logic       misaligned
);

   assign misaligned = is_misaligned(addr_lsb, mode);

endmodule

// File: rtl/uibi_arbiter.sv
// Arbiter sharing one UIBI bus port between instruction fetch and the LSU.
// Define UIBI_ARB_RR_EN for round-robin tie breaking; otherwise D-side has fixed priority.
module uibi_arbiter
   import uibi_arbiter_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   input  logic [2:0]      i_mode,
   output logic            i_ack,
   output logic            i_rvalid,
   output logic [XLEN-1:0] i_rdata,
   output logic            i_err,
   input  logic            d_req,
   input  logic [XLEN-1:0] d_addr,
   input  logic            d_wr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [2:0]      d_mode,
   output logic            d_ack,
   output logic            d_rvalid,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_err,
   output logic            bus_req,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic            bus_wr,
   output logic [2:0]      bus_mode,
   input  logic            bus_done,
   input  logic [XLEN-1:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   arb_state_t    state;
   logic          owner;
   logic [CW-1:0] cnt;
   logic          i_mis;
   logic          d_mis;
   logic          grant_d;
   logic          idle_go;
   logic          sel_mis;

   uibi_align_check u_align_i (
      .addr_lsb   (i_addr[1:0]),
      .mode       (i_mode),
      .misaligned (i_mis)
   );

   uibi_align_check u_align_d (
      .addr_lsb   (d_addr[1:0]),
      .mode       (d_mode),
      .misaligned (d_mis)
   );

`ifdef UIBI_ARB_RR_EN
   logic last_served;

   // On a tie the side that was not served last wins.
   always_comb begin
      grant_d = d_req;
      if (i_req && d_req) begin
         grant_d = (last_served == ARB_OWN_I);
      end
   end
`else
   always_comb begin
      grant_d = d_req;
   end
`endif

   // Acknowledge is combinational so the requester sees it in the latching cycle.
   assign idle_go = (state == ARB_IDLE) && (i_req || d_req) && !rst;
   assign d_ack   = idle_go && grant_d;
   assign i_ack   = idle_go && !grant_d;
   assign sel_mis = grant_d ? d_mis : i_mis;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         owner     <= ARB_OWN_I;
         cnt       <= '0;
         bus_req   <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wr    <= 1'b0;
         bus_mode  <= BUS_NULL;
         i_rvalid  <= 1'b0;
         i_rdata   <= '0;
         i_err     <= 1'b0;
         d_rvalid  <= 1'b0;
         d_rdata   <= '0;
         d_err     <= 1'b0;
`ifdef UIBI_ARB_RR_EN
         last_served <= ARB_OWN_I;
`endif
      end else begin
         i_rvalid <= 1'b0;
         i_rdata  <= '0;
         i_err    <= 1'b0;
         d_rvalid <= 1'b0;
         d_rdata  <= '0;
         d_err    <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (i_req || d_req) begin
                  owner <= grant_d ? ARB_OWN_D : ARB_OWN_I;
`ifdef UIBI_ARB_RR_EN
                  last_served <= grant_d ? ARB_OWN_D : ARB_OWN_I;
`endif
                  if (sel_mis) begin
                     state <= ARB_RESP;
                     if (grant_d) begin
                        d_rvalid <= 1'b1;
                        d_err    <= 1'b1;
                     end else begin
                        i_rvalid <= 1'b1;
                        i_err    <= 1'b1;
                     end
                  end else begin
                     state     <= ARB_BUSY;
                     cnt       <= '0;
                     bus_req   <= 1'b1;
                     bus_addr  <= grant_d ? d_addr : i_addr;
                     bus_wdata <= grant_d ? d_wdata : '0;
                     bus_wr    <= grant_d && d_wr;
                     bus_mode  <= grant_d ? d_mode : i_mode;
                  end
               end
            end
            ARB_BUSY: begin
               // Completion is checked first so a done on the final count still succeeds.
               if (bus_done) begin
                  state   <= ARB_RESP;
                  bus_req <= 1'b0;
                  if (owner == ARB_OWN_D) begin
                     d_rvalid <= 1'b1;
                     d_rdata  <= bus_rdata;
                  end else begin
                     i_rvalid <= 1'b1;
                     i_rdata  <= bus_rdata;
                  end
               end else if (cnt == CNT_MAX) begin
                  state   <= ARB_RESP;
                  bus_req <= 1'b0;
                  if (owner == ARB_OWN_D) begin
                     d_rvalid <= 1'b1;
                     d_err    <= 1'b1;
                  end else begin
                     i_rvalid <= 1'b1;
                     i_err    <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ARB_RESP: begin
               state <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uibi_arbiter.sv
// Self-checking bench for uibi_arbiter: directed scenarios followed by random
// requests, all checked against a transaction-level model of arbitration and alignment.
module tb_uibi_arbiter;
   import uibi_arbiter_pkg::*;

   localparam int TIMEOUT_TB = 4;

   logic        clk;
   logic        rst;
   logic        i_req, d_req, d_wr;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [2:0]  i_mode, d_mode;
   logic        i_ack, d_ack, i_rvalid, d_rvalid, i_err, d_err;
   logic [31:0] i_rdata, d_rdata;
   logic        bus_req, bus_wr, bus_done;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [2:0]  bus_mode;

   int n_checks = 0;
   int n_fail   = 0;
   bit last_d   = 1'b0;

   uibi_arbiter #(.XLEN(32), .TIMEOUT(TIMEOUT_TB)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_mode(i_mode), .i_ack(i_ack),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata), .d_mode(d_mode),
      .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr),
      .bus_mode(bus_mode), .bus_done(bus_done), .bus_rdata(bus_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic bit model_mis(input logic [31:0] a, input logic [2:0] m);
      case (m)
         BUS_QUAR: return 1'b0;
         BUS_HALF: return (a % 2) != 0;
         BUS_FULL: return (a % 4) != 0;
         default:  return 1'b1;
      endcase
   endfunction

   // One full transaction: request(s), arbitration, bus phase (done after 'delay'
   // bus cycles, or never when delay < 0) and the response cycle.
   task automatic apply_stimulus(input bit i_on, input bit d_on,
                                 input logic [31:0] ia, input logic [2:0] im,
                                 input logic [31:0] da, input logic [2:0] dm,
                                 input bit dw, input logic [31:0] dwd,
                                 input int delay, input logic [31:0] brd);
      bit          win_d;
      bit          mis;
      bit          succ;
      bit          exp_err;
      int          cycles;
      logic [31:0] ea;
      logic [2:0]  em;
      logic [31:0] exp_rd;
      i_req = i_on; d_req = d_on;
      i_addr = ia; i_mode = im;
      d_addr = da; d_mode = dm; d_wr = dw; d_wdata = dwd;
      #1;
      if (i_on && d_on) begin
`ifdef UIBI_ARB_RR_EN
         win_d = !last_d;
`else
         win_d = 1'b1;
`endif
      end else begin
         win_d = d_on;
      end
      check_output("d_ack", d_ack, win_d);
      check_output("i_ack", i_ack, !win_d);
      last_d = win_d;
      ea  = win_d ? da : ia;
      em  = win_d ? dm : im;
      mis = model_mis(ea, em);
      succ = 1'b0;
      step();
      i_req = 1'b0; d_req = 1'b0;
      if (!mis) begin
         check_output("bus_addr", bus_addr, ea);
         check_output("bus_mode", bus_mode, em);
         check_output("bus_wr", bus_wr, win_d && dw);
         check_output("bus_wdata", bus_wdata, win_d ? dwd : 32'h0);
         cycles = 0;
         while (bus_req === 1'b1 && cycles < 50) begin
            if (cycles == delay) begin
               bus_done = 1'b1;
               bus_rdata = brd;
            end
            cycles++;
            step();
            bus_done = 1'b0;
            bus_rdata = $urandom;
         end
         succ = (delay >= 0) && (delay <= TIMEOUT_TB);
         check_output("busy_cycles", cycles, succ ? delay + 1 : TIMEOUT_TB + 1);
      end
      exp_err = mis || !succ;
      exp_rd  = exp_err ? 32'h0 : brd;
      check_output("resp_bus_req", bus_req, 1'b0);
      check_output("own_rvalid", win_d ? d_rvalid : i_rvalid, 1'b1);
      check_output("own_err", win_d ? d_err : i_err, exp_err);
      check_output("own_rdata", win_d ? d_rdata : i_rdata, exp_rd);
      check_output("other_rvalid", win_d ? i_rvalid : d_rvalid, 1'b0);
      check_output("other_rdata", win_d ? i_rdata : d_rdata, 32'h0);
      step();
      check_output("post_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      i_req = 0; d_req = 0; d_wr = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0;
      i_mode = BUS_NULL; d_mode = BUS_NULL;
      bus_done = 0; bus_rdata = 0;
      step();
      step();
      check_output("rst_bus_req", bus_req, 1'b0);
      check_output("rst_bus_addr", bus_addr, 32'h0);
      check_output("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'h0);
      check_output("rst_acks", {30'd0, i_ack, d_ack}, 32'h0);
      rst = 1'b0;
      last_d = 1'b0;
      step();

      // Basic D read
      apply_stimulus(0, 1, 32'h0, BUS_FULL, 32'h100, BUS_FULL, 0, 32'h0, 3, 32'hDEADBEEF);

      // Back-to-back ties, then I alone
      apply_stimulus(1, 1, 32'h200, BUS_FULL, 32'h300, BUS_FULL, 1, 32'h1234, 1, 32'h55AA55AA);
      apply_stimulus(1, 1, 32'h204, BUS_FULL, 32'h304, BUS_HALF, 1, 32'h5678, 0, 32'h11112222);
      apply_stimulus(1, 0, 32'h208, BUS_QUAR, 32'h0, BUS_FULL, 0, 32'h0, 2, 32'h33334444);

      // Misaligned and NULL modes
      apply_stimulus(0, 1, 32'h0, BUS_FULL, 32'h103, BUS_HALF, 1, 32'hABCD, 1, 32'h1);
      apply_stimulus(1, 0, 32'h002, BUS_FULL, 32'h0, BUS_FULL, 0, 32'h0, 1, 32'h2);
      apply_stimulus(0, 1, 32'h0, BUS_FULL, 32'h0, BUS_NULL, 0, 32'h0, 1, 32'h3);

      // Timeout, then done on the final count
      apply_stimulus(0, 1, 32'h0, BUS_FULL, 32'h400, BUS_FULL, 0, 32'h0, -1, 32'h77);
      apply_stimulus(0, 1, 32'h0, BUS_FULL, 32'h404, BUS_FULL, 0, 32'h0, TIMEOUT_TB, 32'h88);

      // Reset two cycles into BUSY abandons the access
      d_req = 1; d_addr = 32'h40; d_mode = BUS_FULL; d_wr = 0;
      step();
      d_req = 0;
      step();
      rst = 1'b1;
      step();
      check_output("midrst_bus_req", bus_req, 1'b0);
      check_output("midrst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'h0);
      rst = 1'b0;
      last_d = 1'b0;
      step();
      step();
      check_output("midrst_late_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'h0);
      bus_done = 1'b1; bus_rdata = 32'hBADBAD00;
      step();
      bus_done = 1'b0;
      check_output("stray_bus_req", bus_req, 1'b0);
      check_output("stray_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'h0);
      step();
      check_output("stray_rvalid2", {30'd0, i_rvalid, d_rvalid}, 32'h0);
      apply_stimulus(0, 1, 32'h0, BUS_FULL, 32'h48, BUS_FULL, 1, 32'hFEED, 2, 32'h9999);

      // I read while D waits: i_rvalid at M+1, d_ack at M+2, bus_req at M+3
      i_req = 1; i_addr = 32'h80; i_mode = BUS_FULL;
      #1;
      check_output("hold_i_ack", i_ack, 1'b1);
      step();
      i_req = 0;
      d_req = 1; d_addr = 32'h84; d_mode = BUS_FULL; d_wr = 0;
      check_output("hold_d_ack_busy", d_ack, 1'b0);
      step();
      check_output("hold_d_ack_busy2", d_ack, 1'b0);
      bus_done = 1; bus_rdata = 32'hCAFEF00D;
      step();
      bus_done = 0;
      check_output("hold_i_rvalid", i_rvalid, 1'b1);
      check_output("hold_i_rdata", i_rdata, 32'hCAFEF00D);
      check_output("hold_d_ack_resp", d_ack, 1'b0);
      check_output("hold_bus_req_resp", bus_req, 1'b0);
      step();
      check_output("hold_d_ack", d_ack, 1'b1);
      check_output("hold_bus_req_idle", bus_req, 1'b0);
      last_d = 1'b1;
      step();
      d_req = 0;
      check_output("hold_bus_req", bus_req, 1'b1);
      check_output("hold_bus_addr", bus_addr, 32'h84);
      bus_done = 1; bus_rdata = 32'h0BADF00D;
      step();
      bus_done = 0;
      check_output("hold_d_rvalid", d_rvalid, 1'b1);
      check_output("hold_d_rdata", d_rdata, 32'h0BADF00D);
      step();

      // Random requests
      for (int n = 0; n < 40; n++) begin
         bit ion, don;
         ion = 1'($urandom_range(0, 1));
         don = 1'($urandom_range(0, 1));
         if (!ion && !don) don = 1'b1;
         apply_stimulus(ion, don,
                        $urandom, 3'($urandom_range(0, 4)),
                        $urandom, 3'($urandom_range(0, 4)),
                        1'($urandom_range(0, 1)), $urandom,
                        $urandom_range(0, TIMEOUT_TB + 1), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
